audio_frame_buffer: RTL and testbench
=====================================

// Module: audio_frame_buffer
// PURPOSE
//  Collects filtered audio samples from the low-pass FIR stage into fixed-length frames.
//  Each sample arrives as a one-cycle strobe, at roughly 1 in 2000+ clocks.
//  Ping-pong double buffer: one bank fills while the other is streamed out.
//  Output is a valid/ready/last stream into the transcription FFT.
//  Sits directly downstream of fir_filter (filtered_audio / data_ready).
// PARAMETERS
//  SAMPLE_W    8    sample width; two's complement; passed through bit-exact
//  FRAME_LEN   256  samples per frame; power of 2, >= 4
//  DROP_CNT_W  16   width of dropped-sample counter (DROP_COUNT_EN only)
// PORTS
//  clk_in           in   1           system clock (100 MHz)
//  rst_n_in         in   1           asynchronous, active-low reset
//  sample_in        in   SAMPLE_W    filtered sample from fir_filter
//  sample_valid_in  in   1           single-cycle strobe; sample_in valid this cycle
//  frame_data_out   out  SAMPLE_W    current output sample
//  frame_valid_out  out  1           frame_data_out valid
//  frame_ready_in   in   1           consumer accepts; handshake = valid & ready
//  frame_last_out   out  1           high with the final (index FRAME_LEN-1) sample
//  overflow_out     out  1           sticky; a sample was dropped since reset
//  drop_count_out   out  DROP_CNT_W  dropped samples, saturating (DROP_COUNT_EN only)
// BEHAVIOUR
//  Reset values: every output 0.
//   - Both banks EMPTY; write bank = 0; write pointer = 0; read FSM in IDLE.
//  Bank states (per bank): EMPTY -> FILLING -> FULL -> READING -> EMPTY.
//  Write side, on sample_valid_in:
//   - Store the sample at wr_ptr in the write bank; wr_ptr++.
//   - At wr_ptr == FRAME_LEN-1: mark the bank FULL and wrap wr_ptr to 0.
//   - Then switch to the other bank if it is EMPTY; otherwise write_stalled = 1.
//   - While stalled, incoming samples are dropped: overflow_out <= 1, drop counter +1 (saturates).
//   - The stall clears the cycle after the other bank returns to EMPTY.
//   - A partial frame is never emitted.
//  Read FSM:
//   - IDLE: if any bank is FULL, take the oldest (FIFO order) -> READING, rd_ptr = 0, issue sync read of addr 0 -> PRIME.
//   - PRIME: one cycle for RAM latency -> STREAM; frame_valid_out = 1 from the next cycle.
//   - STREAM: on handshake rd_ptr++ and issue read of rd_ptr+1.
//     - frame_data_out must hold stable while valid & !ready.
//     - With ready held high, throughput is 1 sample/cycle.
//   - On the handshake with frame_last_out: bank -> EMPTY, valid drops next cycle -> IDLE.
//     - Back-to-back frames therefore have a 2-cycle gap.
//  Latency: last sample of a frame written at cycle t -> frame_valid_out high at t+3.
//  Simultaneous events:
//   - The write bank fills in the same cycle the read bank empties: no stall, no drop; switch occurs.
//   - A strobe in the same cycle the stall clears is dropped; capture resumes on the next strobe.
//  Never writes to a bank in READING/FULL state.
//  Reset mid-frame: all banks EMPTY, in-flight stream aborted (valid -> 0 immediately), overflow cleared.
// CONFIGURATION
//  DROP_COUNT_EN defined:
//   - drop_count_out is a saturating DROP_CNT_W counter of dropped strobes, cleared only by reset.
//  DROP_COUNT_EN undefined:
//   - The counter is not built and drop_count_out is tied to 0.
//   - overflow_out is unaffected either way.
// STRUCTURE
//  audio_pkg (shared):
//   - typedef logic signed [SAMPLE_W-1:0] sample_t
//   - enum bank_state_e {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_READING}
//   - enum rd_state_e {RD_IDLE, RD_PRIME, RD_STREAM}
//  Sub-module pingpong_ram:
//   - Simple dual-port, 1 write + 1 synchronous read, depth 2*FRAME_LEN.
//   - Address MSB = bank select; BRAM-inferable, no reset on contents.
// TESTING  (FRAME_LEN=8 for sim)
//  1. Reset, strobe 8 samples 0x01..0x08 every 20 cycles, ready=1
//     -> 8 beats 0x01..0x08, last only on 0x08, valid 3 cycles after 8th strobe.
//  2. Frame ready, frame_ready_in toggled 1/0 each cycle
//     -> data stable while stalled; exactly 8 handshakes; order preserved.
//  3. ready=0, strobe 20 samples
//     -> banks hold 1..8 and 9..16; 17..20 dropped; overflow_out=1; drop_count_out=4 (EN).
//     -> Then ready=1 -> frames 1..8 then 9..16, then capture resumes.
//  4. 8th strobe of bank B in the same cycle as the last handshake of bank A
//     -> no drop, overflow_out stays 0, B streams after A.
//  5. Assert rst_n_in mid-stream (beat 4 of 8)
//     -> valid/last/overflow 0 asynchronously; next 8 strobes form a clean frame.
//  6. Negative samples 0x80, 0xFF in a frame -> emitted bit-exact.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_pkg : shared types for the audio_frame_buffer block        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package audio_pkg;

   localparam int SAMPLE_W_DEFAULT = 8;

   typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2,
      BANK_READING = 2'd3
   } bank_state_e;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_PRIME  = 2'd1,
      RD_STREAM = 2'd2
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/pingpong_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pingpong_ram : 1W/1R sync-read RAM, address MSB selects the bank  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pingpong_ram
   import audio_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9
) (
   input  logic              clk_in,
   input  logic              wr_en_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [DATA_W-1:0] wr_data_in,
   input  logic [ADDR_W-1:0] rd_addr_in,
   output logic [DATA_W-1:0] rd_data_out
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   // No reset on contents or read register so the array maps onto block RAM.
   always_ff @(posedge clk_in) begin
      if (wr_en_in) begin
         mem_q[wr_addr_in] <= wr_data_in;
      end
      rd_data_q <= mem_q[rd_addr_in];
   end

   assign rd_data_out = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/audio_frame_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_frame_buffer : ping-pong framer, FIR samples -> FFT stream |
// | Optional macro DROP_COUNT_EN builds the dropped-sample counter.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module audio_frame_buffer
   import audio_pkg::*;
#(
   parameter int SAMPLE_W   = 8,
   parameter int FRAME_LEN  = 256,
   parameter int DROP_CNT_W = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [SAMPLE_W-1:0]   sample_in,
   input  logic                  sample_valid_in,
   output logic [SAMPLE_W-1:0]   frame_data_out,
   output logic                  frame_valid_out,
   input  logic                  frame_ready_in,
   output logic                  frame_last_out,
   output logic                  overflow_out,
   output logic [DROP_CNT_W-1:0] drop_count_out
);

   localparam int               PTR_W    = $clog2(FRAME_LEN);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

   bank_state_e      bank_q [2];
   bank_state_e      bank_d [2];
   rd_state_e        rd_state_q;
   rd_state_e        rd_state_d;
   logic             wr_bank_q;
   logic             wr_bank_d;
   logic             rd_bank_q;
   logic             rd_bank_d;
   logic             stalled_q;
   logic             stalled_d;
   logic             overflow_q;
   logic             overflow_d;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;

   logic                wr_other;
   logic                drop;
   logic                handshake;
   logic                last_hs;
   logic                other_free;
   logic                ram_we;
   logic [SAMPLE_W-1:0] ram_dout;

   assign wr_other  = ~wr_bank_q;
   assign drop      = sample_valid_in & stalled_q;
   assign handshake = (rd_state_q == RD_STREAM) & frame_ready_in;
   assign last_hs   = handshake & (rd_ptr_q == LAST_IDX);
   // A bank released by the final handshake this cycle counts as free.
   assign other_free = (bank_q[wr_other] == BANK_EMPTY) |
                       (last_hs & (rd_bank_q == wr_other));

   always_comb begin
      bank_d     = bank_q;
      rd_state_d = rd_state_q;
      rd_bank_d  = rd_bank_q;
      rd_ptr_d   = rd_ptr_q;
      wr_bank_d  = wr_bank_q;
      wr_ptr_d   = wr_ptr_q;
      stalled_d  = stalled_q;
      overflow_d = overflow_q | drop;
      ram_we     = 1'b0;

      // Banks are filled strictly alternately, so reading alternately is FIFO order.
      case (rd_state_q)
         RD_IDLE: begin
            if (bank_q[rd_bank_q] == BANK_FULL) begin
               bank_d[rd_bank_q] = BANK_READING;
               rd_ptr_d          = '0;
               rd_state_d        = RD_PRIME;
            end
         end
         RD_PRIME: begin
            rd_state_d = RD_STREAM;
         end
         RD_STREAM: begin
            if (last_hs) begin
               bank_d[rd_bank_q] = BANK_EMPTY;
               rd_bank_d         = ~rd_bank_q;
               rd_ptr_d          = '0;
               rd_state_d        = RD_IDLE;
            end else if (handshake) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
         end
      endcase

      if (stalled_q) begin
         if (bank_q[wr_other] == BANK_EMPTY) begin
            stalled_d = 1'b0;
            wr_bank_d = wr_other;
         end
      end else if (sample_valid_in) begin
         ram_we = 1'b1;
         if (wr_ptr_q == LAST_IDX) begin
            bank_d[wr_bank_q] = BANK_FULL;
            wr_ptr_d          = '0;
            if (other_free) begin
               wr_bank_d = wr_other;
            end else begin
               stalled_d = 1'b1;
            end
         end else begin
            bank_d[wr_bank_q] = BANK_FILLING;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bank_q     <= '{default: BANK_EMPTY};
         rd_state_q <= RD_IDLE;
         rd_bank_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_bank_q  <= 1'b0;
         wr_ptr_q   <= '0;
         stalled_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         rd_state_q <= rd_state_d;
         rd_bank_q  <= rd_bank_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_bank_q  <= wr_bank_d;
         wr_ptr_q   <= wr_ptr_d;
         stalled_q  <= stalled_d;
         overflow_q <= overflow_d;
      end
   end

   // Reading rd_ptr_d every cycle re-reads the same word while stalled, keeping data stable.
   pingpong_ram #(
      .DATA_W (SAMPLE_W),
      .ADDR_W (PTR_W + 1)
   ) u_ram (
      .clk_in      (clk_in),
      .wr_en_in    (ram_we),
      .wr_addr_in  ({wr_bank_q, wr_ptr_q}),
      .wr_data_in  (sample_in),
      .rd_addr_in  ({rd_bank_q, rd_ptr_d}),
      .rd_data_out (ram_dout)
   );

   assign frame_valid_out = (rd_state_q == RD_STREAM);
   assign frame_last_out  = frame_valid_out & (rd_ptr_q == LAST_IDX);
   assign frame_data_out  = frame_valid_out ? ram_dout : '0;
   assign overflow_out    = overflow_q;

`ifdef DROP_COUNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q;
   logic [DROP_CNT_W-1:0] drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count_out = drop_cnt_q;
`else
   assign drop_count_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_audio_frame_buffer : self-checking bench for audio_frame_buffer|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_audio_frame_buffer;

   localparam int FL = 8;
   localparam int SW = 8;
   localparam int DW = 16;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b1;
   logic [SW-1:0] sample_in = '0;
   logic          sample_valid_in = 1'b0;
   logic [SW-1:0] frame_data_out;
   logic          frame_valid_out;
   logic          frame_ready_in = 1'b0;
   logic          frame_last_out;
   logic          overflow_out;
   logic [DW-1:0] drop_count_out;

   int checks = 0;
   int errors = 0;
   bit rand_rdy = 1'b0;

   logic [SW-1:0] obs_data [$];
   bit            obs_last [$];
   logic [SW-1:0] exp_q [$];

   audio_frame_buffer #(
      .SAMPLE_W   (SW),
      .FRAME_LEN  (FL),
      .DROP_CNT_W (DW)
   ) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .sample_in       (sample_in),
      .sample_valid_in (sample_valid_in),
      .frame_data_out  (frame_data_out),
      .frame_valid_out (frame_valid_out),
      .frame_ready_in  (frame_ready_in),
      .frame_last_out  (frame_last_out),
      .overflow_out    (overflow_out),
      .drop_count_out  (drop_count_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (rst_n_in && frame_valid_out && frame_ready_in) begin
         obs_data.push_back(frame_data_out);
         obs_last.push_back(frame_last_out);
      end
   end

   task automatic do_reset();
      sample_valid_in = 1'b0;
      frame_ready_in  = 1'b0;
      sample_in       = '0;
      @(negedge clk_in);
      rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      obs_data.delete();
      obs_last.delete();
   endtask

   task automatic send_sample(input logic [SW-1:0] v, input int gap);
      @(posedge clk_in); #1;
      sample_in       = v;
      sample_valid_in = 1'b1;
      if (rand_rdy) frame_ready_in = ($urandom_range(0, 3) != 0);
      @(posedge clk_in); #1;
      sample_valid_in = 1'b0;
      repeat (gap) begin
         @(posedge clk_in); #1;
         if (rand_rdy) frame_ready_in = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic wait_beats(input int n, input int budget, output bit ok);
      int c;
      c = 0;
      while (obs_data.size() < n && c < budget) begin
         @(negedge clk_in); #1;
         c++;
      end
      ok = (obs_data.size() >= n);
   endtask

   task automatic test_reset();
      @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      checks++;
      if ({frame_valid_out, frame_last_out, overflow_out} !== 3'b000 || frame_data_out !== '0 || drop_count_out !== '0) begin
         errors++;
         $display("FAIL reset_asserted got v/l/o=%b%b%b data=%h drop=%0d exp all 0",
                  frame_valid_out, frame_last_out, overflow_out, frame_data_out, drop_count_out);
      end
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (3) @(negedge clk_in);
      checks++;
      if ({frame_valid_out, frame_last_out, overflow_out} !== 3'b000 || frame_data_out !== '0 || drop_count_out !== '0) begin
         errors++;
         $display("FAIL reset_released got v/l/o=%b%b%b data=%h drop=%0d exp all 0",
                  frame_valid_out, frame_last_out, overflow_out, frame_data_out, drop_count_out);
      end
   endtask

   task automatic test_basic_frame();
      bit ok;
      do_reset();
      frame_ready_in = 1'b1;
      exp_q.delete();
      for (int i = 1; i <= 7; i++) begin
         exp_q.push_back(SW'(i));
         send_sample(SW'(i), 19);
      end
      exp_q.push_back(SW'(8));
      @(posedge clk_in); #1;
      sample_in = 8'h08;
      sample_valid_in = 1'b1;
      @(posedge clk_in); #1;
      sample_valid_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      checks++;
      if (frame_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL t1_valid_t+2 got %b exp 0", frame_valid_out);
      end
      @(negedge clk_in);
      checks++;
      if (frame_valid_out !== 1'b1) begin
         errors++;
         $display("FAIL t1_valid_t+3 got %b exp 1", frame_valid_out);
      end
      wait_beats(8, 60, ok);
      repeat (10) @(negedge clk_in);
      checks++;
      if (obs_data.size() != 8) begin
         errors++;
         $display("FAIL t1_beat_count got %0d exp 8", obs_data.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== ((i % FL) == FL - 1)) begin
            errors++;
            $display("FAIL t1_beat%0d got %h/%b exp %h/%b", i, obs_data[i], obs_last[i], exp_q[i], (i % FL) == FL - 1);
         end
      end
   endtask

   task automatic test_ready_toggle();
      bit            ok;
      bit            prev_v;
      bit            prev_r;
      bit            prev_l;
      logic [SW-1:0] prev_d;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < FL; i++) begin
         exp_q.push_back(SW'($urandom));
         send_sample(exp_q[i], 3);
      end
      for (int c = 0; c < 50 && frame_valid_out !== 1'b1; c++) @(negedge clk_in);
      checks++;
      if (frame_valid_out !== 1'b1) begin
         errors++;
         $display("FAIL t2_valid got %b exp 1", frame_valid_out);
      end
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_l = 1'b0;
      prev_d = '0;
      for (int c = 0; c < 80 && obs_data.size() < FL; c++) begin
         @(posedge clk_in); #1;
         frame_ready_in = c[0];
         @(negedge clk_in);
         if (prev_v && !prev_r) begin
            checks++;
            if (frame_valid_out !== 1'b1 || frame_data_out !== prev_d || frame_last_out !== prev_l) begin
               errors++;
               $display("FAIL t2_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                        frame_valid_out, frame_data_out, frame_last_out, prev_d, prev_l);
            end
         end
         prev_v = frame_valid_out;
         prev_r = frame_ready_in;
         prev_d = frame_data_out;
         prev_l = frame_last_out;
         #1;
      end
      frame_ready_in = 1'b0;
      repeat (10) @(negedge clk_in);
      checks++;
      if (obs_data.size() != FL) begin
         errors++;
         $display("FAIL t2_handshakes got %0d exp %0d", obs_data.size(), FL);
      end
      for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== ((i % FL) == FL - 1)) begin
            errors++;
            $display("FAIL t2_beat%0d got %h/%b exp %h/%b", i, obs_data[i], obs_last[i], exp_q[i], (i % FL) == FL - 1);
         end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int n_drop;
      do_reset();
      exp_q.delete();
      // With no consumer, two banks hold 2*FL samples; everything after is dropped.
      for (int i = 1; i <= 20; i++) begin
         if (i <= 2 * FL) exp_q.push_back(SW'(i));
         send_sample(SW'(i), 3);
      end
`ifdef DROP_COUNT_EN
      n_drop = 20 - 2 * FL;
`else
      n_drop = 0;
`endif
      @(negedge clk_in);
      checks++;
      if (overflow_out !== 1'b1) begin
         errors++;
         $display("FAIL t3_overflow got %b exp 1", overflow_out);
      end
      checks++;
      if (drop_count_out !== DW'(n_drop)) begin
         errors++;
         $display("FAIL t3_drop_count got %0d exp %0d", drop_count_out, n_drop);
      end
      checks++;
      if (frame_valid_out !== 1'b1 || frame_data_out !== 8'h01) begin
         errors++;
         $display("FAIL t3_held_head got v=%b d=%h exp v=1 d=01", frame_valid_out, frame_data_out);
      end
      frame_ready_in = 1'b1;
      wait_beats(2 * FL, 200, ok);
      repeat (10) @(negedge clk_in);
      for (int i = 21; i < 21 + FL; i++) begin
         exp_q.push_back(SW'(i));
         send_sample(SW'(i), 3);
      end
      wait_beats(3 * FL, 200, ok);
      repeat (5) @(negedge clk_in);
      checks++;
      if (obs_data.size() != exp_q.size()) begin
         errors++;
         $display("FAIL t3_beat_count got %0d exp %0d", obs_data.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== ((i % FL) == FL - 1)) begin
            errors++;
            $display("FAIL t3_beat%0d got %h/%b exp %h/%b", i, obs_data[i], obs_last[i], exp_q[i], (i % FL) == FL - 1);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      bit ok;
      obs_data.delete();
      obs_last.delete();
      frame_ready_in = 1'b1;
      for (int i = 0; i < FL; i++) send_sample(SW'(8'h31 + i), 2);
      wait_beats(4, 100, ok);
      rst_n_in = 1'b0;
      #1;
      checks++;
      if ({frame_valid_out, frame_last_out, overflow_out} !== 3'b000 || drop_count_out !== '0) begin
         errors++;
         $display("FAIL t5_async_reset got v/l/o=%b%b%b drop=%0d exp 0000",
                  frame_valid_out, frame_last_out, overflow_out, drop_count_out);
      end
      checks++;
      if (obs_data.size() != 4 || obs_data[3] !== 8'h34) begin
         errors++;
         $display("FAIL t5_pre_reset_beats got %0d beats exp 4 ending 34", obs_data.size());
      end
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      obs_data.delete();
      obs_last.delete();
      exp_q.delete();
      for (int i = 0; i < FL; i++) begin
         exp_q.push_back(SW'(8'h41 + i));
         send_sample(exp_q[i], 2);
      end
      wait_beats(FL, 100, ok);
      repeat (5) @(negedge clk_in);
      checks++;
      if (obs_data.size() != FL || overflow_out !== 1'b0) begin
         errors++;
         $display("FAIL t5_clean_frame got %0d beats ovf=%b exp %0d beats ovf=0", obs_data.size(), overflow_out, FL);
      end
      for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== ((i % FL) == FL - 1)) begin
            errors++;
            $display("FAIL t5_beat%0d got %h/%b exp %h/%b", i, obs_data[i], obs_last[i], exp_q[i], (i % FL) == FL - 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < FL; i++) begin
         exp_q.push_back(SW'(8'h51 + i));
         send_sample(exp_q[i], 2);
      end
      for (int i = 0; i < FL - 1; i++) begin
         exp_q.push_back(SW'(8'h61 + i));
         send_sample(SW'(8'h61 + i), 2);
      end
      exp_q.push_back(8'h68);
      @(posedge clk_in); #1;
      frame_ready_in = 1'b1;
      repeat (FL - 1) @(posedge clk_in);
      #1;
      sample_in = 8'h68;
      sample_valid_in = 1'b1;
      @(negedge clk_in);
      checks++;
      if (frame_valid_out !== 1'b1 || frame_last_out !== 1'b1) begin
         errors++;
         $display("FAIL t4_coincide got v=%b l=%b exp v=1 l=1", frame_valid_out, frame_last_out);
      end
      @(posedge clk_in); #1;
      sample_valid_in = 1'b0;
      wait_beats(2 * FL, 100, ok);
      repeat (5) @(negedge clk_in);
      checks++;
      if (overflow_out !== 1'b0 || drop_count_out !== '0 || obs_data.size() != 2 * FL) begin
         errors++;
         $display("FAIL t4_no_drop got ovf=%b drop=%0d beats=%0d exp ovf=0 drop=0 beats=%0d",
                  overflow_out, drop_count_out, obs_data.size(), 2 * FL);
      end
      for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== ((i % FL) == FL - 1)) begin
            errors++;
            $display("FAIL t4_beat%0d got %h/%b exp %h/%b", i, obs_data[i], obs_last[i], exp_q[i], (i % FL) == FL - 1);
         end
      end
   endtask

   task automatic test_negative();
      bit            ok;
      logic [SW-1:0] pat [FL];
      pat = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h81, 8'hFE, 8'h01, 8'h80};
      do_reset();
      frame_ready_in = 1'b1;
      exp_q.delete();
      for (int i = 0; i < FL; i++) begin
         exp_q.push_back(pat[i]);
         send_sample(pat[i], 4);
      end
      wait_beats(FL, 60, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL t6_timeout got %0d beats exp %0d", obs_data.size(), FL);
      end
      for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== ((i % FL) == FL - 1)) begin
            errors++;
            $display("FAIL t6_beat%0d got %h/%b exp %h/%b", i, obs_data[i], obs_last[i], exp_q[i], (i % FL) == FL - 1);
         end
      end
   endtask

   task automatic test_random();
      bit            ok;
      logic [SW-1:0] in_q [$];
      int            n_full;
      do_reset();
      in_q.delete();
      exp_q.delete();
      rand_rdy = 1'b1;
      for (int i = 0; i < 4 * FL + 3; i++) begin
         in_q.push_back(SW'($urandom));
         send_sample(in_q[i], $urandom_range(12, 30));
      end
      rand_rdy = 1'b0;
      frame_ready_in = 1'b1;
      // Only whole frames ever reach the output, in arrival order.
      n_full = (in_q.size() / FL) * FL;
      for (int i = 0; i < n_full; i++) exp_q.push_back(in_q[i]);
      wait_beats(n_full, 200, ok);
      repeat (30) @(negedge clk_in);
      checks++;
      if (obs_data.size() != n_full || overflow_out !== 1'b0) begin
         errors++;
         $display("FAIL rnd_count got %0d beats ovf=%b exp %0d beats ovf=0", obs_data.size(), overflow_out, n_full);
      end
      for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== ((i % FL) == FL - 1)) begin
            errors++;
            $display("FAIL rnd_beat%0d got %h/%b exp %h/%b", i, obs_data[i], obs_last[i], exp_q[i], (i % FL) == FL - 1);
         end
      end
   endtask

   initial begin
      #3;
      rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      test_reset();
      test_basic_frame();
      test_ready_toggle();
      test_overflow();
      test_reset_mid_stream();
      test_back_to_back();
      test_negative();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
